// File: rtl/sram_pkg.sv
// Shared types and helpers for the banked SRAM with clear engine.
//   state_t   : clear-engine state (IDLE / CLEAR)
//   clog2     : constant ceil(log2) for deriving bank/row widths
//   BANK_BITS / ROWS : derived values for the default geometry
//                      (A=7, NB=4). The top recomputes them from its
//                      own parameters with clog2.
package sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_A     = 7;
    localparam int DEF_W     = 16;
    localparam int DEF_NB    = 4;
    localparam int BANK_BITS = clog2(DEF_NB);
    localparam int ROWS      = (1 << DEF_A) / DEF_NB;

endpackage

// File: rtl/sram_bank.sv
// One memory bank: 2^AW rows of W bits.
// Ports:
//   i_clk   : clock, write on rising edge
//   i_we    : write strobe
//   i_waddr : write row
//   i_wdata : write data
//   i_raddr : read row
//   o_rdata : asynchronous read data of row i_raddr
// The read is combinational; the top level registers the selected word.
module sram_bank #(
    parameter int AW = 5,
    parameter int W  = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sram_banked_clear.sv
// Simple-dual-port word store split into NB interleaved banks, with a
// clear engine that zeroes one row of every bank per cycle.
// Ports:
//   i_clk, i_rst     : clock; asynchronous active-high reset
//   i_clear          : one-cycle request to zero the whole array
//   o_busy           : high while the clear engine runs
//   i_wr_enable/i_wr_address/i_wr_data : write port
//   i_rd_enable/i_rd_address           : read request
//   o_rd_data/o_rd_valid               : registered read result (1 cycle)
// Bank select is the low address bits, row is the remaining high bits.
module sram_banked_clear
    import sram_pkg::*;
#(
    parameter int A  = 7,
    parameter int W  = 16,
    parameter int NB = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    output logic         o_busy,
    input  logic         i_wr_enable,
    input  logic [A-1:0] i_wr_address,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_enable,
    input  logic [A-1:0] i_rd_address,
    output logic [W-1:0] o_rd_data,
    output logic         o_rd_valid
);

    localparam int L_BANK_BITS = clog2(NB);
    localparam int L_BANK_W    = (L_BANK_BITS > 0) ? L_BANK_BITS : 1;
    localparam int L_ROW_BITS  = A - L_BANK_BITS;
    localparam int L_ROW_W     = (L_ROW_BITS > 0) ? L_ROW_BITS : 1;
    localparam int L_ROWS      = (1 << A) / NB;

    state_t               r_state;
    state_t               w_state_next;
    logic [L_ROW_W-1:0]   r_row_cnt;
    logic [L_ROW_W-1:0]   w_row_cnt_next;
    logic                 w_last_row;

    logic [L_BANK_W-1:0]  w_wr_bank;
    logic [L_BANK_W-1:0]  w_rd_bank;
    logic [L_ROW_W-1:0]   w_wr_row;
    logic [L_ROW_W-1:0]   w_rd_row;

    logic                 w_clearing;
    logic                 w_user_wr;
    logic                 w_user_rd;
    logic                 w_bypass;
    logic [L_ROW_W-1:0]   w_bank_waddr;
    logic [W-1:0]         w_bank_wdata;
    logic [NB-1:0]        w_bank_we;
    logic [W-1:0]         w_bank_rdata [NB];

    logic [W-1:0]         r_rd_data;
    logic                 r_rd_valid;

    // ---------------- clear engine FSM ----------------
    assign w_last_row = (r_row_cnt == L_ROW_W'(L_ROWS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_row_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_row_cnt <= w_row_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_row_cnt_next = r_row_cnt;
        case (r_state)
            CLEAR: begin
                if (w_last_row) begin
                    w_state_next   = IDLE;
                    w_row_cnt_next = '0;
                end else begin
                    w_row_cnt_next = r_row_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (i_clear) begin
                    w_state_next = CLEAR;
                end
            end
            default: begin
                w_state_next   = CLEAR;
                w_row_cnt_next = '0;
            end
        endcase
    end

    assign w_clearing = (r_state == CLEAR);
    assign o_busy     = w_clearing;

    // ---------------- address decode ----------------
    generate
        if (L_BANK_BITS > 0) begin : g_bank_sel
            assign w_wr_bank = i_wr_address[L_BANK_BITS-1:0];
            assign w_rd_bank = i_rd_address[L_BANK_BITS-1:0];
        end else begin : g_bank_single
            assign w_wr_bank = '0;
            assign w_rd_bank = '0;
        end

        if (L_ROW_BITS > 0) begin : g_row_sel
            assign w_wr_row = i_wr_address[A-1:L_BANK_BITS];
            assign w_rd_row = i_rd_address[A-1:L_BANK_BITS];
        end else begin : g_row_single
            assign w_wr_row = '0;
            assign w_rd_row = '0;
        end
    endgenerate

    // A clear request on the same edge as a write wins: the write is dropped.
    assign w_user_wr = i_wr_enable & ~w_clearing & ~i_clear;
    assign w_user_rd = i_rd_enable & ~w_clearing;
    // Only a write that actually lands is forwarded to the read.
    assign w_bypass  = w_user_wr & (i_wr_address == i_rd_address);

    // While clearing, every bank writes zero to the current row.
    assign w_bank_waddr = w_clearing ? r_row_cnt : w_wr_row;
    assign w_bank_wdata = w_clearing ? '0 : i_wr_data;

    // ---------------- banks ----------------
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            assign w_bank_we[gi] = w_clearing |
                                   (w_user_wr && (w_wr_bank == L_BANK_W'(gi)));

            sram_bank #(
                .AW (L_ROW_W),
                .W  (W)
            ) u_bank (
                .i_clk   (i_clk),
                .i_we    (w_bank_we[gi]),
                .i_waddr (w_bank_waddr),
                .i_wdata (w_bank_wdata),
                .i_raddr (w_rd_row),
                .o_rdata (w_bank_rdata[gi])
            );
        end
    endgenerate

    // ---------------- read register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_user_rd;
            if (w_user_rd) begin
                r_rd_data <= w_bypass ? i_wr_data : w_bank_rdata[w_rd_bank];
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_sram_banked_clear.sv
// Randomised and directed bench for sram_banked_clear.
// The driver applies stimulus and updates a word-level model of the array
// (plain memory array + remaining-busy-cycles count); every accepted read
// pushes its expected word into a queue. The monitor checks outputs on the
// falling edge and pops the queue whenever rd_valid is seen.
module tb_sram_banked_clear;
    import sram_pkg::*;

    localparam int A     = 7;
    localparam int W     = 16;
    localparam int NB    = 4;
    localparam int DEPTH = 1 << A;
    localparam int NROWS = DEPTH / NB;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         busy;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;
    logic         rd_valid;

    sram_banked_clear #(.A(A), .W(W), .NB(NB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clear),
        .o_busy       (busy),
        .i_wr_enable  (wr_en),
        .i_wr_address (wr_addr),
        .i_wr_data    (wr_data),
        .i_rd_enable  (rd_en),
        .i_rd_address (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_mem [DEPTH];
    int           m_busy_left;
    logic [W-1:0] exp_q [$];
    bit           tb_done;

    function automatic void model_zero();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endfunction

    // Applies the rules for one rising edge using the inputs present at it.
    function automatic void model_edge();
        if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
        end else begin
            if (rd_en) begin
                if (wr_en && !clear && wr_addr == rd_addr) exp_q.push_back(wr_data);
                else exp_q.push_back(m_mem[rd_addr]);
            end
            if (wr_en && !clear) m_mem[wr_addr] = wr_data;
            if (clear) begin
                m_busy_left = NROWS;
                model_zero();
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic cyc(input bit c, input bit we, input int wa, input int wd,
                       input bit re, input int ra);
        clear   = c;
        wr_en   = we;
        wr_addr = A'(wa);
        wr_data = W'(wd);
        rd_en   = re;
        rd_addr = A'(ra);
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        while (m_busy_left > 0) tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    int           checks;
    int           failures;
    int           busy_run;
    logic [W-1:0] last_data;
    logic [W-1:0] exp_word;

    function automatic void chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_busy", int'(busy), 1);
            chk("reset_rd_valid", int'(rd_valid), 0);
            chk("reset_rd_data", int'(rd_data), 0);
            last_data = '0;
            busy_run  = 0;
        end else begin
            chk("busy", int'(busy), (m_busy_left > 0) ? 1 : 0);
            if (busy) begin
                busy_run = busy_run + 1;
            end else begin
                if (busy_run != 0) chk("busy_length", busy_run, NROWS);
                busy_run = 0;
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    $display("read data 0x%04h expected 0x%04h", rd_data, exp_word);
                    chk("rd_data", int'(rd_data), int'(exp_word));
                    last_data = exp_word;
                end
            end else begin
                chk("rd_data_hold", int'(rd_data), int'(last_data));
            end
            if (tb_done) begin
                chk("reads_outstanding", exp_q.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        busy_run    = 0;
        last_data   = '0;
        tb_done     = 1'b0;
        rst         = 1'b1;
        clear       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        m_busy_left = NROWS;
        model_zero();

        // 1: power-up clear, then fresh contents read as zero
        repeat (3) tick();
        rst = 1'b0;
        wait_idle();
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 63);
        cyc(0, 0, 0, 0, 1, 127);
        cyc(0, 0, 0, 0, 0, 0);

        // 2: bank interleave
        cyc(0, 1, 5, 'hA5A5, 0, 0);
        cyc(0, 0, 0, 0, 1, 5);
        cyc(0, 0, 0, 0, 1, 6);

        // 3: write-first bypass
        cyc(0, 1, 9, 'h0BAD, 0, 0);
        cyc(0, 1, 9, 'h1234, 1, 9);
        cyc(0, 0, 0, 0, 1, 9);

        // 4: fill, clear, traffic during busy is dropped, all zero after
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, i, i, 0, 0);
        cyc(0, 0, 0, 0, 1, 77);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < NROWS; i++)
            cyc(i == 5, 1, $urandom_range(0, DEPTH-1), $urandom, 1, $urandom_range(0, DEPTH-1));
        wait_idle();
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, i);

        // 5: clear beats a same-edge write; the same-edge read sees old data
        cyc(0, 1, 3, 'h0003, 0, 0);
        cyc(1, 1, 3, 'hFFFF, 1, 3);
        wait_idle();
        cyc(0, 0, 0, 0, 1, 3);

        // 6: reset in the middle of a clear restarts it from row 0
        cyc(0, 1, 40, 'h4040, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (10) tick();
        rst = 1'b1;
        m_busy_left = NROWS;
        model_zero();
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        wait_idle();
        cyc(0, 0, 0, 0, 1, 40);

        // randomised traffic, addresses sometimes narrowed to force collisions
        for (int n = 0; n < 600; n++) begin
            automatic bit narrow = ($urandom_range(0, 3) == 0);
            automatic int wa = narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1);
            automatic int ra = narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1);
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, wa,
                $urandom_range(0, 65535), $urandom_range(0, 1) == 1, ra);
        end
        wait_idle();
        repeat (3) tick();
        tb_done = 1'b1;
        repeat (20) @(posedge clk);
    end

endmodule
